uart_rx: RTL

- UART receiver: the receive-side counterpart of the system's existing UART transmitter.
- Format is 8N1: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity.
- Samples the asynchronous serial line with a bit-period counter and validates the start and stop bits.
- Each received byte is presented with a one-cycle valid strobe; the sum/latch datapath consumes it for remote loading of operands.

---
 rtl/uart_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a bit-period counter, start/stop validation.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic [DATA_BITS:0]   shift_ext;
    logic                 valid_n;
    logic                 ferr_n;

    logic                 rxd_meta;
    logic                 rxd_s;
    logic                 rxd_d;
    logic [1:0]           sync_fill;
    logic                 start_edge;

    // Two-flop synchronizer plus previous-sample flop for falling-edge detection.
    // The previous sample is only trusted once the preset values have drained out
    // of the synchronizer, so a line already low at reset release is not a start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta  <= 1'b1;
            rxd_s     <= 1'b1;
            rxd_d     <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            rxd_meta  <= uart_rxd;
            rxd_s     <= rxd_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            rxd_d     <= sync_fill[1] & rxd_s;
        end
    end

    assign start_edge = rxd_d & ~rxd_s;
    assign shift_ext  = {rxd_s, shift};

    // State, datapath and registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            shift        <= shift_n;
            rx_data      <= data_n;
            rx_valid     <= valid_n;
            rx_frame_err <= ferr_n;
            rx_busy      <= (state_n != IDLE);
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        data_n  = rx_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    idx_n = '0;
                    state_n = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shift_n = shift_ext[DATA_BITS:1];
                    cnt_n   = '0;
                    idx_n   = idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rxd_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
